vmem_seq: RTL and testbench
===========================

VMEM_SEQ -- requirements
Module: vmem_seq

Interface
REQ-001 The block SHALL have parameter ELEMS, default 16, meaning the number of elements per vector.
REQ-002 The block SHALL have parameter DW, default 16, meaning the element and memory data width in bits.
REQ-003 The block SHALL have parameter AW, default 16, meaning the memory address width in bits.
REQ-004 Port Clk SHALL be an input of width 1: the single clock; every flop SHALL be clocked on its rising edge.
REQ-005 Port Reset_n SHALL be an input of width 1: reset, asynchronous and active-low.
REQ-006 Port Start SHALL be an input of width 1: a one-cycle request to begin a transfer.
REQ-007 Port Op SHALL be an input of width 1: 0 selects a vector load (vld), 1 selects a vector store (vst).
REQ-008 Port Base SHALL be an input of width AW: the address of element 0.
REQ-009 Port VecIn SHALL be an input of width ELEMS*DW: the store source; element k occupies bits [DW*k+DW-1 : DW*k].
REQ-010 Port Abort SHALL be an input of width 1: terminates the transfer in progress.
REQ-011 Port DataIn SHALL be an input of width DW: memory read data.
REQ-012 Port Addr SHALL be an output of width AW: the memory address.
REQ-013 Port RD SHALL be an output of width 1: the memory read strobe.
REQ-014 Port WR SHALL be an output of width 1: the memory write strobe.
REQ-015 Port DataOut SHALL be an output of width DW: memory write data.
REQ-016 Port VecOut SHALL be an output of width ELEMS*DW: the assembled load vector, using the same element packing as VecIn.
REQ-017 Port VecWR SHALL be an output of width 1: a one-cycle strobe to write VecOut into the vector register file.
REQ-018 Port Busy SHALL be an output of width 1: asserted while a transfer is in progress.
REQ-019 Port Done SHALL be an output of width 1: a one-cycle completion pulse.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, LOAD, DRAIN, STORE and FINISH, with a counter k ranging 0..ELEMS-1.
REQ-021 In IDLE, a Start sample SHALL latch Op, Base and VecIn, clear k, and move to LOAD when Op=0 or to STORE when Op=1.
REQ-022 In LOAD, RD=1 and Addr=Base+k*step SHALL hold every cycle, with k incrementing each cycle.
REQ-023 After the LOAD cycle with k=ELEMS-1, the FSM SHALL move to DRAIN.
REQ-024 Memory read latency SHALL be fixed at 1 cycle: data for an RD issued in cycle n is valid on DataIn during cycle n+1 and SHALL be captured into slot k at the end of cycle n+1.
REQ-025 DRAIN SHALL last 1 cycle, capture the final element, and move to FINISH.
REQ-026 In STORE, WR=1, Addr=Base+k*step and DataOut=element k of the latched VecIn SHALL hold each cycle; after k=ELEMS-1 the FSM SHALL move to FINISH.
REQ-027 FINISH SHALL last 1 cycle: Done=1, VecWR=1 for loads only, then the FSM SHALL return to IDLE.
REQ-028 Latency from the Start sample: a load SHALL complete with Done in cycle ELEMS+2 (18 at default parameters); a store SHALL complete with Done in cycle ELEMS+1 (17).
REQ-029 Busy SHALL be 1 in every state except IDLE.
REQ-030 Start SHALL be ignored while Busy=1; there is no queueing.
REQ-031 RD and WR SHALL never be high in the same cycle.
REQ-032 Outside LOAD, RD SHALL be 0; outside STORE, WR SHALL be 0.
REQ-033 Address arithmetic SHALL be modulo 2^AW: FFFF+1 wraps to 0000 silently.
REQ-034 While Busy=1, Abort SHALL force IDLE on the next edge with no Done and no VecWR; partial load data SHALL be discarded, and memory writes already issued SHALL remain.
REQ-035 Abort and Start in the same IDLE cycle: Start SHALL win.
REQ-036 Abort in FINISH SHALL have no effect; Done SHALL still pulse.
REQ-037 VecOut SHALL hold its value until the next load completes.

Reset
REQ-038 On Reset_n=0, the FSM SHALL go to IDLE and k, Addr, DataOut and VecOut SHALL clear to 0.
REQ-039 On Reset_n=0, RD, WR, VecWR, Busy and Done SHALL all be 0.
REQ-040 Reset asserted mid-transfer SHALL abandon the transfer immediately (asynchronously), with no strobes afterward.
REQ-041 Reset SHALL be released synchronously, and the first Start SHALL be accepted no earlier than the first edge after release.

Configuration
REQ-042 When VMEM_STRIDE_EN is defined, there SHALL be an extra input Stride, AW bits wide, latched at Start, with step=Stride; Stride=0 then repeats the same address for all elements.
REQ-043 When VMEM_STRIDE_EN is undefined, the Stride port SHALL be absent and step SHALL be fixed at 1.

Structure
REQ-044 The shared package SHALL contain the state encoding, the Op encodings (OP_VLD=0, OP_VST=1) and ELEMS/DW/AW defaults, shared with the processor top-level.
REQ-045 The sub-module vmem_addr_gen SHALL hold Base, step and k and produce Addr, including wrap-around.

Verification
REQ-046 Load test: Op=0, Base=0x0100, memory[0x100+i]=0xA000+i -> RD high in cycles 1..16 on Addr 0x0100..0x010F; VecWR and Done in cycle 18; VecOut[15:0]=0xA000 and VecOut[255:240]=0xA00F.
REQ-047 Store test: Op=1, Base=0x0200, VecIn element i=0x5500+i -> WR in cycles 1..16; memory[0x20F]=0x550F; Done in cycle 17; VecWR=0.
REQ-048 Wrap-around test: Base=0xFFF8 load -> Addr sequence 0xFFF8..0xFFFF, then 0x0000..0x0007.
REQ-049 Abort test: Abort asserted in load cycle 5 -> IDLE next cycle, no Done, no VecWR, VecOut unchanged; a Start issued while Busy is ignored.
REQ-050 Reset test: Reset_n low mid-store at cycle 8 -> RD, WR, Busy and Done go to 0 asynchronously; after release, a fresh store completes normally.
REQ-051 Stride test (with VMEM_STRIDE_EN defined): Stride=4, Base=0 -> Addr sequence 0, 4, ..., 0x3C.

Source files
------------

// File: rtl/vmem_seq_pkg.sv
// ---------------------------------------------------------------------------
// vmem_seq_pkg
// Shared definitions for the vector memory sequencer and the processor top:
// FSM state encoding, Op encodings and the default vector geometry.
// Optional feature macro used by the sequencer: VMEM_STRIDE_EN.
// ---------------------------------------------------------------------------
package vmem_seq_pkg;

  // Default vector geometry, also used by the processor top-level
  localparam int ELEMS_DEF = 16;
  localparam int DW_DEF    = 16;
  localparam int AW_DEF    = 16;

  // Op encodings
  localparam logic OP_VLD = 1'b0;
  localparam logic OP_VST = 1'b1;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DRAIN  = 3'd2,
    STORE  = 3'd3,
    FINISH = 3'd4
  } vmemState_t;

  // Width of the element counter; at least one bit even for ELEMS=1
  function automatic int kWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vmem_addr_gen.sv
// ---------------------------------------------------------------------------
// vmem_addr_gen
// Element address generator for the vector memory sequencer. Holds the
// running address (starting at Base), the step and the element index k.
// Addresses wrap modulo 2^AW.
//
// Ports:
//   Clk      - clock, rising edge
//   Reset_n  - asynchronous active-low reset
//   Start    - load Base/Step and clear k
//   Advance  - move to the next element (k+1, Addr+Step)
//   Base     - address of element 0
//   Step     - address increment between elements
//   Addr     - current element address
//   K        - current element index
// ---------------------------------------------------------------------------
module vmem_addr_gen
  import vmem_seq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int KW = 4
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          Advance,
  input  logic [AW-1:0] Base,
  input  logic [AW-1:0] Step,
  output logic [AW-1:0] Addr,
  output logic [KW-1:0] K
);

  logic [AW-1:0] stepReg;

  // The address is kept as a running sum rather than Base+k*step, so no
  // multiplier is needed; the AW-bit adder wraps naturally.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Addr    <= '0;
      stepReg <= '0;
      K       <= '0;
    end else if (Start) begin
      Addr    <= Base;
      stepReg <= Step;
      K       <= '0;
    end else if (Advance) begin
      Addr    <= Addr + stepReg;
      K       <= K + 1'b1;
    end
  end

endmodule

// File: rtl/vmem_seq.sv
// ---------------------------------------------------------------------------
// vmem_seq
// Vector load/store sequencer. A Start request transfers ELEMS elements of
// DW bits between memory and a vector register, one element per cycle.
// Loads assemble the vector from memory (1-cycle read latency) and pulse
// VecWR on completion; stores stream the latched VecIn to memory.
//
// Ports:
//   Clk, Reset_n   - clock (rising edge), asynchronous active-low reset
//   Start, Op      - transfer request; Op 0 = vld, 1 = vst
//   Base           - address of element 0
//   Stride         - element address step (only with VMEM_STRIDE_EN)
//   VecIn          - store source vector, element k at [DW*k +: DW]
//   Abort          - terminate the transfer in progress
//   DataIn         - memory read data
//   Addr, RD, WR   - memory address and read/write strobes
//   DataOut        - memory write data
//   VecOut, VecWR  - assembled load vector and its register-file strobe
//   Busy, Done     - transfer in progress / one-cycle completion pulse
//
// Configuration macro: VMEM_STRIDE_EN adds the Stride input; without it
// the element step is fixed at 1.
// ---------------------------------------------------------------------------
module vmem_seq
  import vmem_seq_pkg::*;
#(
  parameter int ELEMS = ELEMS_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Start,
  input  logic                Op,
  input  logic [AW-1:0]       Base,
`ifdef VMEM_STRIDE_EN
  input  logic [AW-1:0]       Stride,
`endif
  input  logic [ELEMS*DW-1:0] VecIn,
  input  logic                Abort,
  input  logic [DW-1:0]       DataIn,
  output logic [AW-1:0]       Addr,
  output logic                RD,
  output logic                WR,
  output logic [DW-1:0]       DataOut,
  output logic [ELEMS*DW-1:0] VecOut,
  output logic                VecWR,
  output logic                Busy,
  output logic                Done
);

  localparam int KW = kWidth(ELEMS);
  localparam logic [KW-1:0] KMAX = KW'(ELEMS - 1);

  vmemState_t          state;
  logic                opLatched;
  logic [ELEMS*DW-1:0] vecLatched;
  logic [ELEMS*DW-1:0] loadBuf;
  logic [ELEMS*DW-1:0] bufNext;
  logic                capValid;
  logic [KW-1:0]       capIdx;
  logic                rdReg;
  logic                wrReg;
  logic                doneReg;
  logic                vecWrReg;
  logic                busyReg;
  logic [DW-1:0]       dataOutReg;
  logic [ELEMS*DW-1:0] vecOutReg;
  logic [KW-1:0]       kCur;
  logic [AW-1:0]       stepSel;
  logic                startAccept;
  logic                addrAdvance;

`ifdef VMEM_STRIDE_EN
  assign stepSel = Stride;
`else
  assign stepSel = AW'(1);
`endif

  // Start is only honoured in IDLE; it outranks a simultaneous Abort there
  assign startAccept = (state == IDLE) && Start;

  // k stops at the last element so Addr still shows it during DRAIN/FINISH
  assign addrAdvance = ((state == LOAD) || (state == STORE)) && !Abort && (kCur != KMAX);

  vmem_addr_gen #(
    .AW (AW),
    .KW (KW)
  ) uAddrGen (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (startAccept),
    .Advance (addrAdvance),
    .Base    (Base),
    .Step    (stepSel),
    .Addr    (Addr),
    .K       (kCur)
  );

  // Read data returns one cycle after RD, so the slot to fill is the index
  // remembered from the previous LOAD cycle, merged here into the buffer.
  always_comb begin
    bufNext = loadBuf;
    if (capValid) begin
      bufNext[int'(capIdx)*DW +: DW] = DataIn;
    end
  end

  // Sequencer FSM with registered strobes. Partial load data lives in
  // loadBuf and only reaches VecOut when DRAIN completes, so an abort leaves
  // VecOut untouched.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      opLatched  <= OP_VLD;
      vecLatched <= '0;
      loadBuf    <= '0;
      capValid   <= 1'b0;
      capIdx     <= '0;
      rdReg      <= 1'b0;
      wrReg      <= 1'b0;
      doneReg    <= 1'b0;
      vecWrReg   <= 1'b0;
      busyReg    <= 1'b0;
      dataOutReg <= '0;
      vecOutReg  <= '0;
    end else begin
      doneReg  <= 1'b0;
      vecWrReg <= 1'b0;
      capValid <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            opLatched  <= Op;
            vecLatched <= VecIn;
            busyReg    <= 1'b1;
            if (Op == OP_VLD) begin
              state <= LOAD;
              rdReg <= 1'b1;
            end else begin
              state      <= STORE;
              wrReg      <= 1'b1;
              dataOutReg <= VecIn[DW-1:0];
            end
          end
        end
        LOAD: begin
          if (Abort) begin
            state   <= IDLE;
            rdReg   <= 1'b0;
            busyReg <= 1'b0;
          end else begin
            loadBuf  <= bufNext;
            capValid <= 1'b1;
            capIdx   <= kCur;
            if (kCur == KMAX) begin
              state <= DRAIN;
              rdReg <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (Abort) begin
            state   <= IDLE;
            busyReg <= 1'b0;
          end else begin
            vecOutReg <= bufNext;
            state     <= FINISH;
            doneReg   <= 1'b1;
            vecWrReg  <= (opLatched == OP_VLD);
          end
        end
        STORE: begin
          if (Abort) begin
            state   <= IDLE;
            wrReg   <= 1'b0;
            busyReg <= 1'b0;
          end else if (kCur == KMAX) begin
            state   <= FINISH;
            wrReg   <= 1'b0;
            doneReg <= 1'b1;
          end else begin
            dataOutReg <= vecLatched[(int'(kCur) + 1)*DW +: DW];
          end
        end
        FINISH: begin
          state   <= IDLE;
          busyReg <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          rdReg   <= 1'b0;
          wrReg   <= 1'b0;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  assign RD      = rdReg;
  assign WR      = wrReg;
  assign Done    = doneReg;
  assign VecWR   = vecWrReg;
  assign Busy    = busyReg;
  assign DataOut = dataOutReg;
  assign VecOut  = vecOutReg;

endmodule

// File: tb/tb_vmem_seq.sv
// ---------------------------------------------------------------------------
// tb_vmem_seq
// Directed self-checking bench for vmem_seq at default parameters
// (ELEMS=16, DW=16, AW=16). A small memory model answers reads one cycle
// after RD from a fixed address pattern and records writes.
// ---------------------------------------------------------------------------
module tb_vmem_seq;
  import vmem_seq_pkg::*;

  logic          Clk;
  logic          Reset_n;
  logic          Start;
  logic          Op;
  logic [15:0]   Base;
`ifdef VMEM_STRIDE_EN
  logic [15:0]   Stride;
`endif
  logic [255:0]  VecIn;
  logic          Abort;
  logic [15:0]   DataIn;
  logic [15:0]   Addr;
  logic          RD;
  logic          WR;
  logic [15:0]   DataOut;
  logic [255:0]  VecOut;
  logic          VecWR;
  logic          Busy;
  logic          Done;

  int checks;
  int errors;

  logic [15:0]  wmem [0:65535];
  logic [255:0] lastVec;

  logic [15:0] wrapAddrs [0:15] = '{
    16'hFFF8, 16'hFFF9, 16'hFFFA, 16'hFFFB, 16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF,
    16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007
  };

  vmem_seq dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .Op      (Op),
    .Base    (Base),
`ifdef VMEM_STRIDE_EN
    .Stride  (Stride),
`endif
    .VecIn   (VecIn),
    .Abort   (Abort),
    .DataIn  (DataIn),
    .Addr    (Addr),
    .RD      (RD),
    .WR      (WR),
    .DataOut (DataOut),
    .VecOut  (VecOut),
    .VecWR   (VecWR),
    .Busy    (Busy),
    .Done    (Done)
  );

  // 10-unit clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Read contents: mem[0x100+i] = 0xA000+i, extended to every address
  function automatic logic [15:0] memPattern(input logic [15:0] a);
    return {4'hA, a[11:0]} - 16'h0100;
  endfunction

  // Memory model: read data appears the cycle after RD, writes land on the edge
  always @(posedge Clk) begin
    if (RD) DataIn <= memPattern(Addr);
    if (WR) wmem[Addr] <= DataOut;
  end

  // Issue a Start from a sample point; returns at the sample point of cycle 1
  task automatic applyStimulus(input logic op, input logic [15:0] base, input logic [255:0] vec);
    Start = 1'b1;
    Op    = op;
    Base  = base;
    VecIn = vec;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    Start   = 1'b0;
    Op      = 1'b0;
    Base    = '0;
    VecIn   = '0;
    Abort   = 1'b0;
`ifdef VMEM_STRIDE_EN
    Stride  = 16'd1;
`endif
    #12;
    checks++; if (RD !== 1'b0)     begin errors++; $display("[TB] FAIL reset RD: got %b expected 0", RD); end
    checks++; if (WR !== 1'b0)     begin errors++; $display("[TB] FAIL reset WR: got %b expected 0", WR); end
    checks++; if (Busy !== 1'b0)   begin errors++; $display("[TB] FAIL reset Busy: got %b expected 0", Busy); end
    checks++; if (Done !== 1'b0)   begin errors++; $display("[TB] FAIL reset Done: got %b expected 0", Done); end
    checks++; if (VecWR !== 1'b0)  begin errors++; $display("[TB] FAIL reset VecWR: got %b expected 0", VecWR); end
    checks++; if (Addr !== 16'h0)  begin errors++; $display("[TB] FAIL reset Addr: got %h expected 0000", Addr); end
    checks++; if (DataOut !== 16'h0) begin errors++; $display("[TB] FAIL reset DataOut: got %h expected 0000", DataOut); end
    checks++; if (VecOut !== 256'h0) begin errors++; $display("[TB] FAIL reset VecOut: got %h expected 0", VecOut); end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_load;
    logic [255:0] expVec;
    for (int i = 0; i < 16; i++) expVec[i*16 +: 16] = 16'hA000 + 16'(i);
    applyStimulus(OP_VLD, 16'h0100, '0);
    for (int c = 1; c <= 18; c++) begin
      checks++; if (RD !== 1'(c <= 16)) begin errors++; $display("[TB] FAIL load RD cycle %0d: got %b expected %b", c, RD, c <= 16); end
      checks++; if (WR !== 1'b0)        begin errors++; $display("[TB] FAIL load WR cycle %0d: got %b expected 0", c, WR); end
      checks++; if (Busy !== 1'b1)      begin errors++; $display("[TB] FAIL load Busy cycle %0d: got %b expected 1", c, Busy); end
      checks++; if (Done !== 1'(c == 18))  begin errors++; $display("[TB] FAIL load Done cycle %0d: got %b expected %b", c, Done, c == 18); end
      checks++; if (VecWR !== 1'(c == 18)) begin errors++; $display("[TB] FAIL load VecWR cycle %0d: got %b expected %b", c, VecWR, c == 18); end
      if (c <= 16) begin
        checks++; if (Addr !== 16'h0100 + 16'(c - 1)) begin errors++; $display("[TB] FAIL load Addr cycle %0d: got %h expected %h", c, Addr, 16'h0100 + 16'(c - 1)); end
      end
      if (c == 18) begin
        checks++; if (VecOut[15:0] !== 16'hA000)    begin errors++; $display("[TB] FAIL load elem0: got %h expected A000", VecOut[15:0]); end
        checks++; if (VecOut[255:240] !== 16'hA00F) begin errors++; $display("[TB] FAIL load elem15: got %h expected A00F", VecOut[255:240]); end
        checks++; if (VecOut !== expVec)            begin errors++; $display("[TB] FAIL load VecOut: got %h expected %h", VecOut, expVec); end
      end
      @(posedge Clk); #1;
    end
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL load Busy after: got %b expected 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL load Done after: got %b expected 0", Done); end
    lastVec = expVec;
  endtask

  task automatic test_store;
    logic [255:0] srcVec;
    for (int i = 0; i < 16; i++) srcVec[i*16 +: 16] = 16'h5500 + 16'(i);
    applyStimulus(OP_VST, 16'h0200, srcVec);
    for (int c = 1; c <= 17; c++) begin
      checks++; if (WR !== 1'(c <= 16))    begin errors++; $display("[TB] FAIL store WR cycle %0d: got %b expected %b", c, WR, c <= 16); end
      checks++; if (RD !== 1'b0)           begin errors++; $display("[TB] FAIL store RD cycle %0d: got %b expected 0", c, RD); end
      checks++; if (Done !== 1'(c == 17))  begin errors++; $display("[TB] FAIL store Done cycle %0d: got %b expected %b", c, Done, c == 17); end
      checks++; if (VecWR !== 1'b0)        begin errors++; $display("[TB] FAIL store VecWR cycle %0d: got %b expected 0", c, VecWR); end
      if (c <= 16) begin
        checks++; if (Addr !== 16'h0200 + 16'(c - 1))    begin errors++; $display("[TB] FAIL store Addr cycle %0d: got %h expected %h", c, Addr, 16'h0200 + 16'(c - 1)); end
        checks++; if (DataOut !== 16'h5500 + 16'(c - 1)) begin errors++; $display("[TB] FAIL store DataOut cycle %0d: got %h expected %h", c, DataOut, 16'h5500 + 16'(c - 1)); end
      end
      @(posedge Clk); #1;
    end
    checks++; if (Busy !== 1'b0)          begin errors++; $display("[TB] FAIL store Busy after: got %b expected 0", Busy); end
    checks++; if (wmem[16'h0200] !== 16'h5500) begin errors++; $display("[TB] FAIL store mem200: got %h expected 5500", wmem[16'h0200]); end
    checks++; if (wmem[16'h020F] !== 16'h550F) begin errors++; $display("[TB] FAIL store mem20F: got %h expected 550F", wmem[16'h020F]); end
    checks++; if (VecOut !== lastVec)     begin errors++; $display("[TB] FAIL store VecOut held: got %h expected %h", VecOut, lastVec); end
  endtask

  task automatic test_wrap;
    applyStimulus(OP_VLD, 16'hFFF8, '0);
    for (int c = 1; c <= 18; c++) begin
      if (c <= 16) begin
        checks++; if (Addr !== wrapAddrs[c-1]) begin errors++; $display("[TB] FAIL wrap Addr cycle %0d: got %h expected %h", c, Addr, wrapAddrs[c-1]); end
      end
      if (c == 18) begin
        checks++; if (VecOut[15:0] !== 16'hAEF8)    begin errors++; $display("[TB] FAIL wrap elem0: got %h expected AEF8", VecOut[15:0]); end
        checks++; if (VecOut[143:128] !== 16'h9F00) begin errors++; $display("[TB] FAIL wrap elem8: got %h expected 9F00", VecOut[143:128]); end
        checks++; if (VecOut[255:240] !== 16'h9F07) begin errors++; $display("[TB] FAIL wrap elem15: got %h expected 9F07", VecOut[255:240]); end
        checks++; if (Done !== 1'b1)                begin errors++; $display("[TB] FAIL wrap Done: got %b expected 1", Done); end
        lastVec = VecOut;
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_abort;
    logic [255:0] heldVec;
    heldVec = lastVec;
    applyStimulus(OP_VLD, 16'h0300, '0);
    for (int c = 1; c <= 9; c++) begin
      if (c <= 5) begin
        checks++; if (RD !== 1'b1) begin errors++; $display("[TB] FAIL abort RD cycle %0d: got %b expected 1", c, RD); end
        checks++; if (WR !== 1'b0) begin errors++; $display("[TB] FAIL abort WR cycle %0d: got %b expected 0", c, WR); end
        checks++; if (Addr !== 16'h0300 + 16'(c - 1)) begin errors++; $display("[TB] FAIL abort Addr cycle %0d: got %h expected %h", c, Addr, 16'h0300 + 16'(c - 1)); end
      end else begin
        checks++; if (Busy !== 1'b0)  begin errors++; $display("[TB] FAIL abort Busy cycle %0d: got %b expected 0", c, Busy); end
        checks++; if (RD !== 1'b0)    begin errors++; $display("[TB] FAIL abort RD cycle %0d: got %b expected 0", c, RD); end
        checks++; if (Done !== 1'b0)  begin errors++; $display("[TB] FAIL abort Done cycle %0d: got %b expected 0", c, Done); end
        checks++; if (VecWR !== 1'b0) begin errors++; $display("[TB] FAIL abort VecWR cycle %0d: got %b expected 0", c, VecWR); end
      end
      if (c == 2) begin Start = 1'b1; Op = OP_VST; end
      if (c == 3) Start = 1'b0;
      if (c == 5) Abort = 1'b1;
      if (c == 6) Abort = 1'b0;
      @(posedge Clk); #1;
    end
    checks++; if (VecOut !== heldVec) begin errors++; $display("[TB] FAIL abort VecOut held: got %h expected %h", VecOut, heldVec); end
  endtask

  task automatic test_abort_edges;
    logic [255:0] srcVec;
    for (int i = 0; i < 16; i++) srcVec[i*16 +: 16] = 16'h7700 + 16'(i);
    // Start and Abort together in IDLE: Start wins
    Abort = 1'b1;
    applyStimulus(OP_VST, 16'h0500, srcVec);
    for (int c = 1; c <= 4; c++) begin
      if (c <= 3) begin
        checks++; if (Busy !== 1'b1) begin errors++; $display("[TB] FAIL startwins Busy cycle %0d: got %b expected 1", c, Busy); end
        checks++; if (WR !== 1'b1)   begin errors++; $display("[TB] FAIL startwins WR cycle %0d: got %b expected 1", c, WR); end
      end else begin
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL storeabort Busy: got %b expected 0", Busy); end
        checks++; if (WR !== 1'b0)   begin errors++; $display("[TB] FAIL storeabort WR: got %b expected 0", WR); end
        checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL storeabort Done: got %b expected 0", Done); end
      end
      if (c == 1) Abort = 1'b0;
      if (c == 3) Abort = 1'b1;
      if (c == 4) Abort = 1'b0;
      @(posedge Clk); #1;
    end
    checks++; if (wmem[16'h0502] !== 16'h7702) begin errors++; $display("[TB] FAIL storeabort mem502: got %h expected 7702", wmem[16'h0502]); end
    checks++; if (wmem[16'h0503] === 16'h7703) begin errors++; $display("[TB] FAIL storeabort mem503: got %h expected not 7703", wmem[16'h0503]); end
    // Abort during FINISH is ignored
    applyStimulus(OP_VST, 16'h0600, srcVec);
    for (int c = 1; c <= 18; c++) begin
      if (c == 17) begin
        checks++; if (Done !== 1'b1) begin errors++; $display("[TB] FAIL finishabort Done: got %b expected 1", Done); end
        Abort = 1'b1;
      end
      if (c == 18) begin
        checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL finishabort Busy: got %b expected 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL finishabort Done after: got %b expected 0", Done); end
        Abort = 1'b0;
      end
      @(posedge Clk); #1;
    end
    checks++; if (wmem[16'h060F] !== 16'h770F) begin errors++; $display("[TB] FAIL finishabort mem60F: got %h expected 770F", wmem[16'h060F]); end
  endtask

  task automatic test_reset_mid;
    logic [255:0] srcVec;
    for (int i = 0; i < 16; i++) srcVec[i*16 +: 16] = 16'h6600 + 16'(i);
    applyStimulus(OP_VST, 16'h0400, srcVec);
    for (int c = 1; c < 8; c++) begin
      @(posedge Clk); #1;
    end
    checks++; if (WR !== 1'b1) begin errors++; $display("[TB] FAIL midreset WR before: got %b expected 1", WR); end
    #2;
    Reset_n = 1'b0;
    #1;
    checks++; if (RD !== 1'b0)    begin errors++; $display("[TB] FAIL midreset RD: got %b expected 0", RD); end
    checks++; if (WR !== 1'b0)    begin errors++; $display("[TB] FAIL midreset WR: got %b expected 0", WR); end
    checks++; if (Busy !== 1'b0)  begin errors++; $display("[TB] FAIL midreset Busy: got %b expected 0", Busy); end
    checks++; if (Done !== 1'b0)  begin errors++; $display("[TB] FAIL midreset Done: got %b expected 0", Done); end
    checks++; if (Addr !== 16'h0) begin errors++; $display("[TB] FAIL midreset Addr: got %h expected 0000", Addr); end
    checks++; if (VecOut !== 256'h0) begin errors++; $display("[TB] FAIL midreset VecOut: got %h expected 0", VecOut); end
    @(posedge Clk); #1;
    checks++; if (WR !== 1'b0) begin errors++; $display("[TB] FAIL midreset WR held: got %b expected 0", WR); end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    checks++; if (wmem[16'h0406] !== 16'h6606) begin errors++; $display("[TB] FAIL midreset mem406: got %h expected 6606", wmem[16'h0406]); end
    checks++; if (wmem[16'h0407] === 16'h6607) begin errors++; $display("[TB] FAIL midreset mem407: got %h expected not 6607", wmem[16'h0407]); end
    for (int i = 0; i < 16; i++) srcVec[i*16 +: 16] = 16'h6800 + 16'(i);
    applyStimulus(OP_VST, 16'h0480, srcVec);
    for (int c = 1; c <= 17; c++) begin
      checks++; if (WR !== 1'(c <= 16))   begin errors++; $display("[TB] FAIL poststore WR cycle %0d: got %b expected %b", c, WR, c <= 16); end
      checks++; if (Done !== 1'(c == 17)) begin errors++; $display("[TB] FAIL poststore Done cycle %0d: got %b expected %b", c, Done, c == 17); end
      @(posedge Clk); #1;
    end
    checks++; if (wmem[16'h048F] !== 16'h680F) begin errors++; $display("[TB] FAIL poststore mem48F: got %h expected 680F", wmem[16'h048F]); end
  endtask

`ifdef VMEM_STRIDE_EN
  task automatic test_stride;
    Stride = 16'd4;
    applyStimulus(OP_VLD, 16'h0000, '0);
    Stride = 16'd1;
    for (int c = 1; c <= 18; c++) begin
      if (c <= 16) begin
        checks++; if (Addr !== 16'(4*(c - 1))) begin errors++; $display("[TB] FAIL stride Addr cycle %0d: got %h expected %h", c, Addr, 16'(4*(c - 1))); end
      end
      @(posedge Clk); #1;
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    lastVec = '0;
    test_reset();
    test_load();
    test_store();
    test_wrap();
    test_abort();
    test_abort_edges();
    test_reset_mid();
`ifdef VMEM_STRIDE_EN
    test_stride();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
